// File: rtl/piece_mover.sv
`timescale 1ns/1ps
// piece_mover: falling-piece controller for the Tetris play field.
// Holds the active 4x4-masked piece position and applies keyboard moves
// (A/D with auto-repeat, S soft drop) plus gravity. Every candidate position
// is verified against the board row memory by a 4-row sequential read before
// it is committed. Also maps the current pixel to play-area cell coordinates.
// Optional build macro: HARD_DROP_EN enables the W-key hard-drop loop.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   frame_clk               ~60 Hz frame level, synchronised and edge-detected
//   DrawX, DrawY            current pixel
//   keycode                 last key (A left, D right, S soft drop, W hard drop)
//   spawn, spawn_x          new-piece request and its column
//   piece_mask              4x4 shape, bit r*4+c
//   board_rd_en/row/data    board row read port, data one cycle after enable
//   piece_x, piece_y        active piece position
//   active, busy            piece in play / collision check running
//   lock, top_out           one-cycle landing / spawn-collision pulses
//   play_area, x_coord, y_coord, is_piece   pixel mapping (combinational)
module piece_mover #(
  parameter int unsigned GRID_W         = 10,
  parameter int unsigned GRID_H         = 20,
  parameter int unsigned CELL           = 20,
  parameter int unsigned X_ORIGIN       = 220,
  parameter int unsigned Y_ORIGIN       = 40,
  parameter int unsigned GRAVITY_FRAMES = 15,
  parameter int unsigned REPEAT_FRAMES  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [7:0]        keycode,
  input  logic              spawn,
  input  logic [4:0]        spawn_x,
  input  logic [15:0]       piece_mask,
  output logic              board_rd_en,
  output logic [4:0]        board_rd_row,
  input  logic [GRID_W-1:0] board_rd_data,
  output logic [4:0]        piece_x,
  output logic [4:0]        piece_y,
  output logic              active,
  output logic              busy,
  output logic              lock,
  output logic              top_out,
  output logic              play_area,
  output logic [4:0]        x_coord,
  output logic [4:0]        y_coord,
  output logic              is_piece
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CHK_W = 3;
  localparam logic [7:0]  KEY_A = 8'h04;
  localparam logic [7:0]  KEY_D = 8'h07;
  localparam logic [7:0]  KEY_S = 8'h16;
`ifdef HARD_DROP_EN
  localparam logic [7:0]  KEY_W = 8'h1A;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_COMMIT} state_t;
  typedef enum logic [1:0] {M_SPAWN, M_HORZ, M_DOWN} mode_t;

  state_t                 state_q, state_d;
  mode_t                  mode_q, mode_d;
  logic                   drop_q, drop_d;
  logic signed [6:0]      cand_x_q, cand_x_d;
  logic [5:0]             cand_y_q, cand_y_d;
  logic [CHK_W-1:0]       chk_cnt_q, chk_cnt_d;
  logic                   coll_q, coll_d;
  logic [4:0]             piece_x_q, piece_x_d;
  logic [4:0]             piece_y_q, piece_y_d;
  logic                   active_q, active_d;
  logic                   busy_q, busy_d;
  logic                   lock_q, lock_d;
  logic                   top_out_q, top_out_d;
  logic                   rd_en_q, rd_en_d;
  logic [4:0]             rd_row_q, rd_row_d;
  logic [CNT_W-1:0]       grav_cnt_q, grav_cnt_d;
  logic                   grav_pend_q, grav_pend_d;
  logic [CNT_W-1:0]       rep_cnt_q, rep_cnt_d;
  logic [7:0]             key_prev_q, key_prev_d;
  logic                   fs1_q, fs1_d, fs2_q, fs2_d, fprev_q, fprev_d;

  logic                   fedge, key_new, key_rep, grav_hit;
  logic                   oob, row_coll;
  logic [3:0]             col_used, mrow;
  logic [1:0]             eval_k;
  int                     eval_row;
  int                     px_off, py_off, cx, cy, ddx, ddy;

  // Collision terms: horizontal bounds of the candidate and the row under evaluation
  always_comb begin
    fedge    = fs2_q & ~fprev_q;
    col_used = piece_mask[3:0] | piece_mask[7:4] | piece_mask[11:8] | piece_mask[15:12];
    oob      = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (col_used[c] && ((int'(cand_x_q) + c < 0) || (int'(cand_x_q) + c >= int'(GRID_W))))
        oob = 1'b1;
    end
    // Cycle k+1 of CHECK evaluates the data read for row k
    eval_k   = 2'(chk_cnt_q - CHK_W'(1));
    mrow     = piece_mask[{eval_k, 2'b00} +: 4];
    eval_row = int'(cand_y_q) + int'(eval_k);
    row_coll = 1'b0;
    if (eval_row >= int'(GRID_H)) begin
      row_coll = |mrow;
    end else begin
      for (int b = 0; b < int'(GRID_W); b++) begin
        for (int c = 0; c < 4; c++) begin
          if (mrow[c] && board_rd_data[b] && (int'(cand_x_q) + c == b))
            row_coll = 1'b1;
        end
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    drop_d      = drop_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    chk_cnt_d   = chk_cnt_q;
    coll_d      = coll_q;
    piece_x_d   = piece_x_q;
    piece_y_d   = piece_y_q;
    active_d    = active_q;
    lock_d      = 1'b0;
    top_out_d   = 1'b0;
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    rep_cnt_d   = rep_cnt_q;
    key_prev_d  = key_prev_q;
    fs1_d       = frame_clk;
    fs2_d       = fs1_q;
    fprev_d     = fs2_q;

    // Key history and auto-repeat run on every frame edge regardless of state
    key_new = fedge && (keycode != key_prev_q);
    key_rep = fedge && !key_new && (rep_cnt_q == CNT_W'(REPEAT_FRAMES - 1));
    if (fedge) begin
      key_prev_d = keycode;
      rep_cnt_d  = (key_new || key_rep) ? '0 : rep_cnt_q + CNT_W'(1);
    end

    // Gravity counts even while busy; the wrapping edge itself can trigger a step
    grav_hit = fedge && active_q && (grav_cnt_q == CNT_W'(GRAVITY_FRAMES - 1));
    if (fedge && active_q) grav_cnt_d = grav_hit ? '0 : grav_cnt_q + CNT_W'(1);
    if (grav_hit) grav_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (spawn) begin
          cand_x_d  = 7'(spawn_x);
          cand_y_d  = '0;
          mode_d    = M_SPAWN;
          drop_d    = 1'b0;
          chk_cnt_d = '0;
          state_d   = S_CHECK;
        end
      end
      S_WAIT: begin
        if (fedge) begin
          cand_x_d  = 7'(piece_x_q);
          cand_y_d  = 6'(piece_y_q);
          chk_cnt_d = '0;
          drop_d    = 1'b0;
          if ((key_new || key_rep) && (keycode == KEY_A)) begin
            cand_x_d = 7'(piece_x_q) - 7'd1;
            mode_d   = M_HORZ;
            state_d  = S_CHECK;
          end else if ((key_new || key_rep) && (keycode == KEY_D)) begin
            cand_x_d = 7'(piece_x_q) + 7'd1;
            mode_d   = M_HORZ;
            state_d  = S_CHECK;
`ifdef HARD_DROP_EN
          end else if (key_new && (keycode == KEY_W)) begin
            cand_y_d = 6'(piece_y_q) + 6'd1;
            mode_d   = M_DOWN;
            drop_d   = 1'b1;
            state_d  = S_CHECK;
`endif
          end else if ((keycode == KEY_S) || grav_pend_q || grav_hit) begin
            cand_y_d = 6'(piece_y_q) + 6'd1;
            mode_d   = M_DOWN;
            state_d  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        coll_d    = (chk_cnt_q == '0) ? oob : (coll_q | row_coll);
        chk_cnt_d = chk_cnt_q + CHK_W'(1);
        if (chk_cnt_q == CHK_W'(4)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        case (mode_q)
          M_SPAWN: begin
            if (coll_q) begin
              top_out_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              piece_x_d   = 5'(cand_x_q);
              piece_y_d   = 5'(cand_y_q);
              active_d    = 1'b1;
              grav_cnt_d  = '0;
              grav_pend_d = 1'b0;
              state_d     = S_WAIT;
            end
          end
          M_HORZ: begin
            if (!coll_q) piece_x_d = 5'(cand_x_q);
            state_d = S_WAIT;
          end
          default: begin
            if (coll_q) begin
              lock_d   = 1'b1;
              active_d = 1'b0;
              drop_d   = 1'b0;
              state_d  = S_IDLE;
            end else begin
              piece_y_d   = 5'(cand_y_q);
              grav_cnt_d  = '0;
              grav_pend_d = 1'b0;
              state_d     = S_WAIT;
              // Hard drop chains straight into the next row check
              if (drop_q) begin
                cand_y_d  = cand_y_q + 6'd1;
                chk_cnt_d = '0;
                state_d   = S_CHECK;
              end
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Read strobe is registered, so it is decoded from the next-state values
    busy_d   = (state_d == S_CHECK) || (state_d == S_COMMIT);
    rd_en_d  = (state_d == S_CHECK) && (chk_cnt_d < CHK_W'(4)) &&
               (int'(cand_y_d) + int'(chk_cnt_d) < int'(GRID_H));
    rd_row_d = 5'(cand_y_d + 6'(chk_cnt_d));
  end

  // State registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_SPAWN;
      drop_q      <= 1'b0;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      chk_cnt_q   <= '0;
      coll_q      <= 1'b0;
      piece_x_q   <= '0;
      piece_y_q   <= '0;
      active_q    <= 1'b0;
      busy_q      <= 1'b0;
      lock_q      <= 1'b0;
      top_out_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_row_q    <= '0;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      rep_cnt_q   <= '0;
      key_prev_q  <= '0;
      fs1_q       <= 1'b0;
      fs2_q       <= 1'b0;
      fprev_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      drop_q      <= drop_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      chk_cnt_q   <= chk_cnt_d;
      coll_q      <= coll_d;
      piece_x_q   <= piece_x_d;
      piece_y_q   <= piece_y_d;
      active_q    <= active_d;
      busy_q      <= busy_d;
      lock_q      <= lock_d;
      top_out_q   <= top_out_d;
      rd_en_q     <= rd_en_d;
      rd_row_q    <= rd_row_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      rep_cnt_q   <= rep_cnt_d;
      key_prev_q  <= key_prev_d;
      fs1_q       <= fs1_d;
      fs2_q       <= fs2_d;
      fprev_q     <= fprev_d;
    end
  end

  // Pixel to cell mapping; coordinates forced to 0 outside the play area
  always_comb begin
    px_off    = int'(DrawX) - int'(X_ORIGIN);
    py_off    = int'(DrawY) - int'(Y_ORIGIN);
    play_area = (px_off >= 0) && (px_off < int'(GRID_W * CELL)) &&
                (py_off >= 0) && (py_off < int'(GRID_H * CELL));
    cx        = play_area ? px_off / int'(CELL) : 0;
    cy        = play_area ? py_off / int'(CELL) : 0;
    x_coord   = 5'(cx);
    y_coord   = 5'(cy);
    ddx       = cx - int'(piece_x_q);
    ddy       = cy - int'(piece_y_q);
    is_piece  = active_q && play_area && (ddx >= 0) && (ddx < 4) && (ddy >= 0) && (ddy < 4) &&
                piece_mask[{2'(ddy), 2'(ddx)}];
  end

  assign board_rd_en  = rd_en_q;
  assign board_rd_row = rd_row_q;
  assign piece_x      = piece_x_q;
  assign piece_y      = piece_y_q;
  assign active       = active_q;
  assign busy         = busy_q;
  assign lock         = lock_q;
  assign top_out      = top_out_q;

endmodule

// File: tb/tb_piece_mover.sv
`timescale 1ns/1ps
// tb_piece_mover: directed self-checking bench for piece_mover.
module tb_piece_mover;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [7:0]  keycode = '0;
  logic        spawn = 1'b0;
  logic [4:0]  spawn_x = '0;
  logic [15:0] piece_mask = 16'h0033;
  logic        board_rd_en;
  logic [4:0]  board_rd_row;
  logic [9:0]  board_rd_data;
  logic [4:0]  piece_x, piece_y, x_coord, y_coord;
  logic        active, busy, lock, top_out, play_area, is_piece;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] board [32];
  int         rd_rows [$];
  int         lock_cycles = 0;
  int         top_cycles  = 0;

  piece_mover dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .keycode(keycode), .spawn(spawn), .spawn_x(spawn_x), .piece_mask(piece_mask),
    .board_rd_en(board_rd_en), .board_rd_row(board_rd_row), .board_rd_data(board_rd_data),
    .piece_x(piece_x), .piece_y(piece_y), .active(active), .busy(busy), .lock(lock),
    .top_out(top_out), .play_area(play_area), .x_coord(x_coord), .y_coord(y_coord),
    .is_piece(is_piece)
  );

  always #10 Clk = ~Clk;

  // Board memory with one-cycle read latency, plus event monitors
  always @(posedge Clk) begin
    if (board_rd_en) begin
      board_rd_data <= board[board_rd_row];
      rd_rows.push_back(int'(board_rd_row));
    end
    if (lock)    lock_cycles <= lock_cycles + 1;
    if (top_out) top_cycles  <= top_cycles + 1;
  end

  task automatic clear_board();
    for (int i = 0; i < 32; i++) board[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; keycode = '0; spawn = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_spawn(input logic [4:0] sx, input logic [15:0] m);
    @(negedge Clk);
    spawn_x = sx; piece_mask = m; spawn = 1'b1;
    @(negedge Clk);
    spawn = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic do_frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (12) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (12) @(negedge Clk);
  endtask

  task automatic test_reset();
    clear_board();
    DrawX = '0; DrawY = '0;
    do_reset();
    n_tests++;
    if ({active, busy, lock, top_out, board_rd_en, play_area} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {active, busy, lock, top_out, board_rd_en, play_area});
    end
    n_tests++;
    if ({piece_x, piece_y} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", piece_x, piece_y);
    end
  endtask

  task automatic test_spawn();
    int r0, l0, t0, n;
    bit ok;
    r0 = rd_rows.size(); l0 = lock_cycles; t0 = top_cycles;
    do_spawn(5'd3, 16'h0033);
    n_tests++;
    if ({active, busy, piece_x, piece_y} !== {1'b1, 1'b0, 5'd3, 5'd0}) begin
      n_fail++;
      $display("FAIL spawn_state: got active=%0d busy=%0d pos=(%0d,%0d) expected 1 0 (3,0)",
               active, busy, piece_x, piece_y);
    end
    n_tests++;
    if ((lock_cycles - l0) != 0 || (top_cycles - t0) != 0) begin
      n_fail++;
      $display("FAIL spawn_pulses: got lock=%0d top_out=%0d expected 0 0",
               lock_cycles - l0, top_cycles - t0);
    end
    n = rd_rows.size() - r0;
    ok = (n == 4);
    if (ok) for (int i = 0; i < 4; i++) if (rd_rows[r0 + i] != i) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL spawn_reads: got %0d reads expected rows 0,1,2,3", n);
    end
  endtask

  task automatic test_left_repeat();
    int exp_x [13] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    keycode = 8'h04;
    for (int f = 0; f < 13; f++) begin
      do_frame();
      n_tests++;
      if (piece_x !== 5'(exp_x[f])) begin
        n_fail++;
        $display("FAIL left_repeat_frame%0d: got x=%0d expected %0d", f + 1, piece_x, exp_x[f]);
      end
    end
    n_tests++;
    if ({active, piece_y} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL left_wall: got active=%0d y=%0d expected 1 0", active, piece_y);
    end
    keycode = '0;
  endtask

  task automatic test_pixel();
    logic [9:0] vx [8] = '{10'd240, 10'd219, 10'd260, 10'd220, 10'd419, 10'd420, 10'd240, 10'd239};
    logic [9:0] vy [8] = '{10'd60,  10'd60,  10'd80,  10'd40,  10'd439, 10'd60,  10'd440, 10'd59};
    // expected {play_area, x_coord, y_coord, is_piece} for piece (0,0), mask 0x0033
    logic [11:0] ve [8] = '{{1'b1, 5'd1, 5'd1,  1'b1}, {1'b0, 5'd0, 5'd0, 1'b0},
                            {1'b1, 5'd2, 5'd2,  1'b0}, {1'b1, 5'd0, 5'd0, 1'b1},
                            {1'b1, 5'd9, 5'd19, 1'b0}, {1'b0, 5'd0, 5'd0, 1'b0},
                            {1'b0, 5'd0, 5'd0,  1'b0}, {1'b1, 5'd0, 5'd0, 1'b1}};
    for (int i = 0; i < 8; i++) begin
      DrawX = vx[i]; DrawY = vy[i];
      #1;
      n_tests++;
      if ({play_area, x_coord, y_coord, is_piece} !== ve[i]) begin
        n_fail++;
        $display("FAIL pixel_%0d_%0d: got pa=%0d x=%0d y=%0d ip=%0d expected %h",
                 vx[i], vy[i], play_area, x_coord, y_coord, is_piece, ve[i]);
      end
    end
  endtask

  task automatic test_latency();
    int r0;
    logic [4:0] xs [10];
    logic       bs [10];
    r0 = rd_rows.size();
    @(negedge Clk);
    keycode = 8'h07; frame_clk = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge Clk);
      xs[i] = piece_x; bs[i] = busy;
    end
    n_tests++;
    if ({bs[2], bs[3]} !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_rise: got %b expected 01", {bs[2], bs[3]});
    end
    n_tests++;
    if ({xs[8], xs[9]} !== {5'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL move_latency: got x=%0d then %0d expected 0 then 1", xs[8], xs[9]);
    end
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (12) @(negedge Clk);
    n_tests++;
    if ((rd_rows.size() - r0) != 4 || rd_rows[r0] != 0 || rd_rows[r0 + 3] != 3) begin
      n_fail++;
      $display("FAIL move_reads: got %0d reads expected rows 0..3", rd_rows.size() - r0);
    end
    keycode = '0;
  endtask

  task automatic test_right_wall();
    do_reset();
    do_spawn(5'd8, 16'h0033);
    keycode = 8'h07;
    do_frame();
    n_tests++;
    if ({active, piece_x} !== {1'b1, 5'd8}) begin
      n_fail++;
      $display("FAIL right_wall: got active=%0d x=%0d expected 1 8", active, piece_x);
    end
    keycode = '0;
  endtask

  task automatic test_gravity();
    int r0, ey;
    bit ok;
    do_reset();
    clear_board();
    do_spawn(5'd3, 16'h0033);
    r0 = 0;
    for (int f = 1; f <= 30; f++) begin
      if (f == 30) r0 = rd_rows.size();
      do_frame();
      ey = (f >= 30) ? 2 : ((f >= 15) ? 1 : 0);
      n_tests++;
      if (piece_y !== 5'(ey)) begin
        n_fail++;
        $display("FAIL gravity_frame%0d: got y=%0d expected %0d", f, piece_y, ey);
      end
    end
    ok = ((rd_rows.size() - r0) == 4);
    if (ok) for (int i = 0; i < 4; i++) if (rd_rows[r0 + i] != i + 2) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL gravity_reads: got %0d reads expected rows 2,3,4,5", rd_rows.size() - r0);
    end
  endtask

  task automatic test_lock();
    int l0;
    do_reset();
    clear_board();
    board[19] = 10'h3FF;
    do_spawn(5'd3, 16'h0033);
    keycode = 8'h16;
    repeat (16) do_frame();
    n_tests++;
    if (piece_y !== 5'd16) begin
      n_fail++;
      $display("FAIL soft_drop: got y=%0d expected 16", piece_y);
    end
    keycode = '0;
    l0 = lock_cycles;
    repeat (15) do_frame();
    n_tests++;
    if ({active, piece_y} !== {1'b1, 5'd17} || lock_cycles != l0) begin
      n_fail++;
      $display("FAIL pre_lock: got active=%0d y=%0d locks=%0d expected 1 17 0",
               active, piece_y, lock_cycles - l0);
    end
    repeat (15) do_frame();
    n_tests++;
    if ({active, busy, piece_y} !== {1'b0, 1'b0, 5'd17} || (lock_cycles - l0) != 1) begin
      n_fail++;
      $display("FAIL lock: got active=%0d busy=%0d y=%0d lock_cycles=%0d expected 0 0 17 1",
               active, busy, piece_y, lock_cycles - l0);
    end
  endtask

  task automatic test_top_out();
    int l0, t0;
    do_reset();
    clear_board();
    board[0] = 10'h010;
    l0 = lock_cycles; t0 = top_cycles;
    do_spawn(5'd3, 16'h0033);
    n_tests++;
    if ({active, busy} !== 2'b00 || (top_cycles - t0) != 1 || lock_cycles != l0) begin
      n_fail++;
      $display("FAIL top_out: got active=%0d busy=%0d top_cycles=%0d locks=%0d expected 0 0 1 0",
               active, busy, top_cycles - t0, lock_cycles - l0);
    end
    // back-to-back: IDLE accepts a new spawn once the board is clear
    clear_board();
    do_spawn(5'd3, 16'h0033);
    n_tests++;
    if ({active, piece_x, piece_y} !== {1'b1, 5'd3, 5'd0}) begin
      n_fail++;
      $display("FAIL respawn: got active=%0d pos=(%0d,%0d) expected 1 (3,0)",
               active, piece_x, piece_y);
    end
  endtask

  task automatic test_spawn_ignored();
    int r0;
    r0 = rd_rows.size();
    do_spawn(5'd7, 16'h0033);
    n_tests++;
    if ({piece_x, busy} !== {5'd3, 1'b0} || rd_rows.size() != r0) begin
      n_fail++;
      $display("FAIL spawn_ignored: got x=%0d busy=%0d reads=%0d expected 3 0 0",
               piece_x, busy, rd_rows.size() - r0);
    end
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    @(negedge Clk);
    spawn_x = 5'd3; spawn = 1'b1;
    @(negedge Clk);
    spawn = 1'b0;
    @(negedge Clk);
    n_tests++;
    if ({board_rd_en, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_check: got rd_en=%0d busy=%0d expected 1 1", board_rd_en, busy);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_tests++;
    if ({board_rd_en, busy, active} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_check: got rd_en=%0d busy=%0d active=%0d expected 0 0 0",
               board_rd_en, busy, active);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_left_repeat();
    test_pixel();
    test_latency();
    test_right_wall();
    test_gravity();
    test_lock();
    test_top_out();
    test_spawn_ignored();
    test_reset_mid_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
